// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall, flush and freeze control for a five-stage in-order pipeline.
//   The write enables and flushes are a same-cycle combinational decode of
//   the current state and inputs. State, the memory wait counter, the stall
//   counter and the timeout flag are registered.
//
// Parameters
//   TIMEOUT      consecutive dmem_busy cycles tolerated in MEM_WAIT (2..255)
//   CNT_W        width of stall_count
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      synchronous, active-low reset
//   if_id_rs1    rs1 field of the instruction in ID
//   if_id_rs2    rs2 field of the instruction in ID
//   id_ex_MemRead instruction in EX is a load
//   id_ex_rd     destination register of the instruction in EX
//   branch_taken branch/jump resolved taken in EX this cycle
//   dmem_busy    data memory cannot complete the MEM access this cycle
//   PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write   register load enables
//   IF_ID_Flush, ID_EX_Flush                          bubble/NOP insertion
//   stall_count  saturating count of cycles with PCWrite=0
//   mem_timeout  sticky memory-timeout error flag
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t           state_reg;
  logic [7:0]       wait_cnt_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic             mem_timeout_reg;
  logic             load_use;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign stall_count = stall_count_reg;
  assign mem_timeout = mem_timeout_reg;

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    if (!reset_n) begin
      // Hold everything and keep NOPs flowing into the pipe while in reset.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (state_reg == ST_ERROR || dmem_busy) begin
      // Full freeze: nothing moves, nothing is cleared.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (branch_taken) begin
      // Squash the two wrong-path instructions; any load-use in ID is moot.
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject one bubble. The bubble has MemRead=0, so
      // the hazard clears on the following cycle.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= ST_RUN;
      wait_cnt_reg    <= 8'd0;
      stall_count_reg <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      if (!PCWrite && (stall_count_reg != {CNT_W{1'b1}})) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
      case (state_reg)
        ST_RUN: begin
          if (dmem_busy) begin
            state_reg    <= ST_MEM_WAIT;
            wait_cnt_reg <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_busy) begin
            if (wait_cnt_reg < TIMEOUT_L) begin
              wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end else begin
              state_reg       <= ST_ERROR;
              mem_timeout_reg <= 1'b1;
            end
          end else begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 8'd0;
          end
        end
        ST_ERROR: begin
          // Terminal until reset.
          mem_timeout_reg <= 1'b1;
        end
        default: begin
          state_reg    <= ST_RUN;
          wait_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max consecutive dmem_busy cycles tolerated in MEM_WAIT (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of stall_count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port if_id_rs1  input  5  rs1 field of the instruction in ID.
REQ-006 SHALL have port if_id_rs2  input  5  rs2 field of the instruction in ID.
REQ-007 SHALL have port id_ex_MemRead  input  1  instruction in EX is a load.
REQ-008 SHALL have port id_ex_rd  input  5  destination register of the instruction in EX.
REQ-009 SHALL have port branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 SHALL have port dmem_busy  input  1  data memory cannot complete the MEM-stage access this cycle.
REQ-011 SHALL have port PCWrite  output  1  PC update enable.
REQ-012 SHALL have port IF_ID_Write  output  1  IF/ID register load enable.
REQ-013 SHALL have port IF_ID_Flush  output  1  IF/ID register cleared to NOP.
REQ-014 SHALL have port ID_EX_Flush  output  1  ID/EX control cleared (bubble insertion).
REQ-015 SHALL have port ID_EX_Write  output  1  ID/EX register load enable.
REQ-016 SHALL have port EX_MEM_Write  output  1  EX/MEM and MEM/WB register load enable.
REQ-017 SHALL have port stall_count  output  CNT_W  saturating count of cycles with PCWrite=0 (reset_n=1 only).
REQ-018 SHALL have port mem_timeout  output  1  sticky error flag.

Function
REQ-019 SHALL implement a 3-state FSM: RUN, MEM_WAIT, ERROR; plus 8-bit wait_cnt.
REQ-020 Outputs SHALL be combinational from current state and inputs (same-cycle response); state/counters registered.
REQ-021 Default (no hazard): PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=1, both flushes=0.
REQ-022 load_use SHALL be id_ex_MemRead=1 and id_ex_rd!=0 and (id_ex_rd==if_id_rs1 or id_ex_rd==if_id_rs2).
REQ-023 Priority in RUN, and in MEM_WAIT with dmem_busy=0: dmem_busy > branch_taken > load_use > default.
REQ-024 dmem_busy=1 (RUN or MEM_WAIT): all four write enables=0, both flushes=0 (full freeze).
REQ-025 RUN with dmem_busy=1: next state MEM_WAIT, wait_cnt<=1.
REQ-026 MEM_WAIT with dmem_busy=1 and wait_cnt<TIMEOUT: stay, wait_cnt+1; wait_cnt==TIMEOUT: next ERROR, mem_timeout<=1.
REQ-027 MEM_WAIT with dmem_busy=0: outputs per REQ-023 priority, next RUN, wait_cnt<=0.
REQ-028 branch_taken (not frozen): PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, other enables 1; load_use ignored that cycle.
REQ-029 load_use (not frozen, no branch): PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, ID_EX_Write=1, EX_MEM_Write=1; exactly one bubble per load since bubble has MemRead=0.
REQ-030 ERROR: all write enables=0, flushes=0, mem_timeout=1; exit only via reset.
REQ-031 stall_count SHALL increment each posedge where PCWrite=0, saturate at all-ones, never wrap.

Reset
REQ-032 reset_n=0 at posedge: state<=RUN, wait_cnt<=0, stall_count<=0, mem_timeout<=0, regardless of current state (incl. mid-MEM_WAIT or ERROR).
REQ-033 While reset_n=0: PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, IF_ID_Flush=ID_EX_Flush=1; stall_count not incremented.

Verification
REQ-034 Load-use: id_ex_MemRead=1, id_ex_rd=5, if_id_rs2=5, one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead=0) defaults; stall_count=1.
REQ-035 rd=x0: id_ex_MemRead=1, id_ex_rd=0, if_id_rs1=0 -> default outputs, stall_count unchanged.
REQ-036 Branch+load-use same cycle: branch_taken=1 with REQ-034 hazard -> PCWrite=1, both flushes=1, no stall.
REQ-037 Memory wait: dmem_busy=1 for 3 cycles with branch_taken=1 held -> 3 frozen cycles, then flush cycle, state RUN, stall_count=3.
REQ-038 Timeout: TIMEOUT=4, dmem_busy held 6 cycles -> ERROR after posedge with wait_cnt==4, mem_timeout=1 persists after dmem_busy=0; reset_n=0 one cycle -> RUN, mem_timeout=0, stall_count=0.
